// File: rtl/dsp_mac_unit.sv
// dsp_mac_unit: MMIO multiply-accumulate peripheral with a configurable
// pipeline, sticky overflow and RESULT reads that wait for the drain.
module dsp_mac_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  host_address,
    input  logic        host_write_en,
    input  logic        host_read_en,
    input  logic [31:0] host_write_data,
    output logic [31:0] host_read_data,
    output logic        host_ready,
    output logic        busy
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int HW = ACC_WIDTH - 32;
    localparam logic [31:0] HI_MASK = ~32'((64'd1 << HW) - 64'd1);

    localparam logic [2:0] ADDR_A    = 3'd0;
    localparam logic [2:0] ADDR_B    = 3'd1;
    localparam logic [2:0] ADDR_CTRL = 3'd2;
    localparam logic [2:0] ADDR_LO   = 3'd3;
    localparam logic [2:0] ADDR_HI   = 3'd4;
    localparam logic [2:0] ADDR_STAT = 3'd5;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_STALL,
        RD_WAIT_LOW
    } rd_state_t;

    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [1:0]            mode_q, mode_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  ovf_q, ovf_d;
    logic                  last_sgn_q, last_sgn_d;
    logic                  done_q, done_d;

    logic [LATENCY-1:0]    st_v_q, st_v_d;
    logic [LATENCY-1:0]    st_sgn_q, st_sgn_d;
    logic [LATENCY-1:0]    st_acc_q, st_acc_d;
    logic [ACC_WIDTH-1:0]  st_p_q [LATENCY];
    logic [ACC_WIDTH-1:0]  st_p_d [LATENCY];

    rd_state_t             rd_state_q, rd_state_d;
    logic [2:0]            rd_addr_q, rd_addr_d;
    logic                  ready_q, ready_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  issue;
    logic                  clr;
    logic [PW-1:0]         a_ext, b_ext, prod;
    logic [ACC_WIDTH-1:0]  iss_p, fin_p;
    logic                  fin_v, fin_sgn, fin_acc;
    logic [ACC_WIDTH:0]    sum;
    logic                  add_ovf;
    logic [63:0]           acc_pad;
    logic                  hi_ext;
    logic [31:0]           res_hi, rd_val;
    logic [2:0]            mux_addr;
    logic                  is_res;
    logic                  unused_wdata;

    assign issue = host_write_en && (host_address == ADDR_B);
    assign clr   = host_write_en && (host_address == ADDR_CTRL)
                   && host_write_data[2];
    assign unused_wdata = ^host_write_data;

    // Product is formed at issue so later A/CTRL writes cannot touch it.
    always_comb begin
        if (mode_q[0]) begin
            a_ext = PW'($signed(a_q));
            b_ext = PW'($signed(host_write_data[DATA_WIDTH-1:0]));
        end else begin
            a_ext = PW'(a_q);
            b_ext = PW'(host_write_data[DATA_WIDTH-1:0]);
        end
        prod = a_ext * b_ext;
        if (mode_q[0]) begin
            iss_p = ACC_WIDTH'($signed(prod));
        end else begin
            iss_p = ACC_WIDTH'(prod);
        end
    end

    always_comb begin
        st_v_d[0]   = issue;
        st_sgn_d[0] = mode_q[0];
        st_acc_d[0] = mode_q[1];
        st_p_d[0]   = iss_p;
        for (int i = 1; i < LATENCY; i++) begin
            st_v_d[i]   = st_v_q[i-1];
            st_sgn_d[i] = st_sgn_q[i-1];
            st_acc_d[i] = st_acc_q[i-1];
            st_p_d[i]   = st_p_q[i-1];
        end
    end

    assign fin_v   = st_v_q[LATENCY-1];
    assign fin_sgn = st_sgn_q[LATENCY-1];
    assign fin_acc = st_acc_q[LATENCY-1];
    assign fin_p   = st_p_q[LATENCY-1];
    assign busy    = |st_v_q;

    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, fin_p};
        if (fin_sgn) begin
            add_ovf = (acc_q[ACC_WIDTH-1] == fin_p[ACC_WIDTH-1])
                      && (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        end else begin
            add_ovf = sum[ACC_WIDTH];
        end
    end

    always_comb begin
        a_d        = a_q;
        mode_d     = mode_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        last_sgn_d = last_sgn_q;
        done_d     = done_q;
        if (host_write_en && host_address == ADDR_A) begin
            a_d = host_write_data[DATA_WIDTH-1:0];
        end
        if (host_write_en && host_address == ADDR_CTRL) begin
            mode_d = host_write_data[1:0];
        end
        // A clear on the completion cycle means accumulate from zero.
        if (fin_v) begin
            last_sgn_d = fin_sgn;
            done_d     = 1'b1;
            if (clr) begin
                acc_d = fin_p;
                ovf_d = 1'b0;
            end else if (fin_acc) begin
                acc_d = sum[ACC_WIDTH-1:0];
                ovf_d = ovf_q | add_ovf;
            end else begin
                acc_d = fin_p;
            end
        end else if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    assign acc_pad = 64'(acc_q);
    assign hi_ext  = done_q & last_sgn_q & acc_q[ACC_WIDTH-1];
    assign res_hi  = acc_pad[63:32] | (hi_ext ? HI_MASK : 32'd0);

    always_comb begin
        mux_addr = (rd_state_q == RD_STALL) ? rd_addr_q : host_address;
        rd_val   = '0;
        unique case (mux_addr)
            ADDR_CTRL: rd_val = {30'd0, mode_q};
            ADDR_LO:   rd_val = acc_pad[31:0];
            ADDR_HI:   rd_val = res_hi;
            ADDR_STAT: rd_val = {30'd0, ovf_q, busy};
            default:   rd_val = '0;
        endcase
    end

    assign is_res = (host_address == ADDR_LO) || (host_address == ADDR_HI);

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        ready_d    = 1'b0;
        rdata_d    = '0;
        unique case (rd_state_q)
            RD_IDLE: begin
                if (host_read_en) begin
                    rd_addr_d = host_address;
                    if (is_res && (busy || issue)) begin
                        rd_state_d = RD_STALL;
                    end else begin
                        ready_d    = 1'b1;
                        rdata_d    = rd_val;
                        rd_state_d = RD_WAIT_LOW;
                    end
                end
            end
            RD_STALL: begin
                if (!busy && !issue) begin
                    ready_d    = 1'b1;
                    rdata_d    = rd_val;
                    rd_state_d = RD_WAIT_LOW;
                end
            end
            RD_WAIT_LOW: begin
                if (!host_read_en) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_WAIT_LOW;
        endcase
    end

    assign host_ready     = ready_q;
    assign host_read_data = rdata_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q        <= '0;
            mode_q     <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            last_sgn_q <= 1'b0;
            done_q     <= 1'b0;
            st_v_q     <= '0;
            st_sgn_q   <= '0;
            st_acc_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                st_p_q[i] <= '0;
            end
            rd_state_q <= RD_WAIT_LOW;
            rd_addr_q  <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            a_q        <= a_d;
            mode_q     <= mode_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            last_sgn_q <= last_sgn_d;
            done_q     <= done_d;
            st_v_q     <= st_v_d;
            st_sgn_q   <= st_sgn_d;
            st_acc_q   <= st_acc_d;
            for (int i = 0; i < LATENCY; i++) begin
                st_p_q[i] <= st_p_d[i];
            end
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: doc/dsp_mac_unit.md
Name: dsp_mac_unit

Overview:
Parametrised successor to the fixed 16x16 signed MMIO multiplier. It adds selectable signed/unsigned mode, a wide accumulator with a sticky overflow flag, and configurable pipeline depth. Operations can be issued back-to-back, and result reads stall on a ready handshake until the pipeline drains. It sits on the CPU peripheral bus in the vdp_clk domain and is selected by the address decoder's dsp_en/dsp_write_en.

Parameters:
DATA_WIDTH, 16, operand width (2..32)
ACC_WIDTH, 40, accumulator width (max(32, 2*DATA_WIDTH)..64)
LATENCY, 2, pipeline stages from issue to accumulator update (1..4)

Ports:
clk  input  1  peripheral clock
resetn  input  1  asynchronous active-low reset
host_address  input  3  register select (word index)
host_write_en  input  1  single-cycle write strobe
host_read_en  input  1  read request; held high until host_ready
host_write_data  input  32  write data
host_read_data  output  32  read data, valid while host_ready=1
host_ready  output  1  one-cycle read completion pulse
busy  output  1  any pipeline stage valid

Behaviour:
- Register map:
  - 0 = A (write-only, low DATA_WIDTH bits)
  - 1 = B (write issues an op)
  - 2 = CTRL: bit0 signed, bit1 accumulate, bit2 clear (write-1 pulse, not stored); reads back {bit1, bit0}
  - 3 = RESULT_LO
  - 4 = RESULT_HI
  - 5 = STATUS: bit0 busy, bit1 overflow
  - 6, 7 read 0, writes ignored
- Reset (async, resetn=0): A, B, CTRL, acc, overflow, all stage valids = 0; host_ready=0; host_read_data=0; busy=0.
- Issue: a write to addr 1 latches B and launches an op into stage 1, using the new B, the current A, and the current CTRL mode bits (mode captured per op).
  - One issue per cycle accepted; no backpressure on writes.
  - A and CTRL writes never affect ops already in flight.
- Product: 2*DATA_WIDTH bits, signed or unsigned per the op's mode, then sign- or zero-extended to ACC_WIDTH.
- Final stage (LATENCY cycles after the issue write):
  - accumulate=1: acc <= acc + ext_product, modulo 2^ACC_WIDTH.
  - accumulate=0: acc <= ext_product.
- Overflow (sticky):
  - Signed op: set when the signed addition overflows ACC_WIDTH.
  - Unsigned op: set on carry out.
  - Never set by non-accumulate ops.
- Clear (CTRL bit2 write):
  - acc <= 0 and overflow <= 0 that cycle.
  - If an op completes the same cycle, acc <= ext_product (accumulate from zero); overflow stays 0.
- busy = OR of stage valids.
  - Asserted the cycle after an issue write.
  - Deasserts the cycle after the final-stage update.
- Reads:
  - Any address other than 3/4: host_ready pulses one cycle after host_read_en rises, with data registered.
  - Addr 3/4 while busy=1 or an issue write is in the same cycle: host_ready held 0 until busy=0, then pulses the next cycle with the post-update acc.
  - RESULT_LO = acc[31:0].
  - RESULT_HI = acc[ACC_WIDTH-1:32], extended to 32 bits per the last completed op's mode (zero if no op has completed since reset).
- host_read_en must drop after host_ready.
  - A new read is only recognised after host_read_en has been low for at least one cycle.
  - host_ready never pulses twice per request.
- Simultaneous write and read on the same cycle: the write takes effect; the read sees pre-write state, except for the result-stall rule above.
- Reset mid-operation: all in-flight ops are discarded, and an outstanding read is abandoned (no ready pulse).

Test Plan:
- Signed, no-acc: A=0xFFFE (-2), B=0x0003 -> busy 1 for LATENCY cycles; RESULT_LO=0xFFFFFFFA, RESULT_HI=0xFFFFFFFF, overflow=0.
- Unsigned, no-acc: A=0xFFFF, B=0xFFFF -> RESULT_LO=0xFFFE0001, RESULT_HI=0.
- Back-to-back accumulate: clear, then B writes on 4 consecutive cycles with A=0x0010 and B=1,2,3,4 -> RESULT_LO=0xA0; a read issued the cycle after the last write stalls until busy=0, then returns 0xA0.
- Unsigned overflow at ACC_WIDTH=40: 0xFFFF*0xFFFF accumulated 257 times -> overflow=1, acc = 257*0xFFFE0001 mod 2^40; a clear write then gives overflow=0, acc=0.
- Clear colliding with the final stage: issue 5*7 with accumulate=1 onto acc=100, clear landing exactly on its completion cycle -> RESULT_LO=35.
- Async reset mid-pipeline with a stalled RESULT read -> host_ready never pulses; after release busy=0 and RESULT_LO/HI=0.
